// File: rtl/localcfg_mem_ctl.sv
// Access controller in front of the local-config single-port RAM: round-robin
// arbitration between the TV80 memory bus and a config-loader req/ack port.
module localcfg_mem_ctl #(
  parameter int unsigned width   = 8,
  parameter int unsigned addr_sz = 8,
  parameter logic [15:0] base    = 16'h0080
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [15:0]        cpu_addr,
  input  logic [width-1:0]   cpu_dout,
  input  logic               cpu_mreq_n,
  input  logic               cpu_rd_n,
  input  logic               cpu_wr_n,
  output logic [width-1:0]   cpu_din,
  output logic               cpu_wait_n,
  input  logic               cfg_req,
  input  logic               cfg_we,
  input  logic [addr_sz-1:0] cfg_addr,
  input  logic [width-1:0]   cfg_wdata,
  output logic               cfg_ack,
  output logic [width-1:0]   cfg_rdata,
  output logic               mem_wr_en,
  output logic               mem_rd_en,
  output logic [addr_sz-1:0] mem_addr,
  output logic [width-1:0]   mem_d_in,
  input  logic [width-1:0]   mem_d_out
);

  localparam int unsigned HI_W = 16 - addr_sz;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               owner_cfg_q, owner_cfg_d;
  logic               last_cfg_q, last_cfg_d;
  logic               cpu_served_q, cpu_served_d;
  logic               cfg_ack_q, cfg_ack_d;
  logic               mem_wr_en_q, mem_wr_en_d;
  logic               mem_rd_en_q, mem_rd_en_d;
  logic [addr_sz-1:0] mem_addr_q, mem_addr_d;
  logic [width-1:0]   mem_d_in_q, mem_d_in_d;
  logic [width-1:0]   cpu_din_q, cpu_din_d;
  logic [width-1:0]   cfg_rdata_q, cfg_rdata_d;
  logic               done;

  logic cpu_sel, cpu_pend, cfg_pend, grant_cpu, grant_cfg;

  // Request qualification; cpu_served limits the CPU to one RAM access per bus cycle
  assign cpu_sel   = ~cpu_mreq_n & (cpu_addr[15:addr_sz] == base[HI_W-1:0]);
  assign cpu_pend  = cpu_sel & (~cpu_rd_n | ~cpu_wr_n) & ~cpu_served_q;
  assign cfg_pend  = cfg_req & ~cfg_ack_q;
  assign grant_cpu = (state_q == IDLE) & cpu_pend & (~cfg_pend | last_cfg_q);
  assign grant_cfg = (state_q == IDLE) & cfg_pend & ~grant_cpu;

  assign cpu_wait_n = ~cpu_pend;
  assign cpu_din    = cpu_din_q;
  assign cfg_ack    = cfg_ack_q;
  assign cfg_rdata  = cfg_rdata_q;
  assign mem_wr_en  = mem_wr_en_q;
  assign mem_rd_en  = mem_rd_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_d_in   = mem_d_in_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_cfg_q  <= 1'b0;
      last_cfg_q   <= 1'b1;
      cpu_served_q <= 1'b0;
      cfg_ack_q    <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_d_in_q   <= '0;
      cpu_din_q    <= '0;
      cfg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_cfg_q  <= owner_cfg_d;
      last_cfg_q   <= last_cfg_d;
      cpu_served_q <= cpu_served_d;
      cfg_ack_q    <= cfg_ack_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_d_in_q   <= mem_d_in_d;
      cpu_din_q    <= cpu_din_d;
      cfg_rdata_q  <= cfg_rdata_d;
    end
  end

  // Grant latches the request straight into the RAM-facing registers; strobes live one cycle
  always_comb begin
    state_d     = state_q;
    owner_cfg_d = owner_cfg_q;
    last_cfg_d  = last_cfg_q;
    mem_wr_en_d = 1'b0;
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_d_in_d  = mem_d_in_q;
    cpu_din_d   = cpu_din_q;
    cfg_rdata_d = cfg_rdata_q;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_cpu) begin
          owner_cfg_d = 1'b0;
          last_cfg_d  = 1'b0;
          mem_addr_d  = cpu_addr[addr_sz-1:0];
          mem_d_in_d  = cpu_dout;
          mem_wr_en_d = cpu_rd_n;
          mem_rd_en_d = ~cpu_rd_n;
          state_d     = ISSUE;
        end else if (grant_cfg) begin
          owner_cfg_d = 1'b1;
          last_cfg_d  = 1'b1;
          mem_addr_d  = cfg_addr;
          mem_d_in_d  = cfg_wdata;
          mem_wr_en_d = cfg_we;
          mem_rd_en_d = ~cfg_we;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_wr_en_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (owner_cfg_q) cfg_rdata_d = mem_d_out;
        else             cpu_din_d   = mem_d_out;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cfg_ack_d    = done & owner_cfg_q;
    cpu_served_d = cpu_mreq_n ? 1'b0 : (cpu_served_q | (done & ~owner_cfg_q));
  end

endmodule
